// File: rtl/rexta_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and load/store (LS).
// Optional performance counters are enabled with `define REXTA_ARB_PERF_EN.
//
// state | meaning
// IDLE  | no transaction owned; arbitrate and accept one request
// REQ   | latched request presented on mem_req_*, waiting for mem_req_ready
// WAIT  | request accepted by memory, waiting for mem_rsp_valid
module rexta_mem_arbiter #(
    parameter int ADDR_W           = 32,
    parameter int DATA_W           = 32,
    parameter int FETCH_STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_rdata,
    input  logic                ls_req_valid,
    input  logic                ls_req_we,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wstrb,
    output logic                ls_req_ready,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    output logic                busy
`ifdef REXTA_ARB_PERF_EN
    ,
    output logic [31:0]         perf_if_grants,
    output logic [31:0]         perf_ls_grants,
    output logic [31:0]         perf_stall_cycles
`endif
);

    localparam int CNT_W = $clog2(FETCH_STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(FETCH_STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t           state;
    logic             owner_ls;
    logic [CNT_W-1:0] starve_cnt;
    logic             in_idle;
    logic             if_grant;
    logic             ls_grant;
    logic             in_wait_rsp;

    // Ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        in_idle     = (state == ST_IDLE) & rst_n;
        if_grant    = if_req_valid & (~ls_req_valid | (starve_cnt == STARVE_MAX));
        ls_grant    = ls_req_valid & ~if_grant;
        in_wait_rsp = (state == ST_WAIT) & mem_rsp_valid;
    end

    assign if_req_ready = in_idle & if_grant;
    assign ls_req_ready = in_idle & ls_grant;
    assign if_rsp_valid = in_wait_rsp & ~owner_ls;
    assign ls_rsp_valid = in_wait_rsp & owner_ls;
    assign if_rsp_rdata = mem_rsp_rdata;
    assign ls_rsp_rdata = mem_rsp_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            owner_ls      <= 1'b0;
            starve_cnt    <= '0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_req_ready) begin
                        owner_ls      <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= if_req_addr;
                        mem_req_wdata <= '0;
                        mem_req_wstrb <= '0;
                        starve_cnt    <= '0;
                        busy          <= 1'b1;
                        state         <= ST_REQ;
                    end else if (ls_req_ready) begin
                        owner_ls      <= 1'b1;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= ls_req_we;
                        mem_req_addr  <= ls_req_addr;
                        mem_req_wdata <= ls_req_wdata;
                        mem_req_wstrb <= ls_req_we ? ls_req_wstrb : '0;
                        busy          <= 1'b1;
                        state         <= ST_REQ;
                        if (!if_req_valid) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_MAX) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (!if_req_valid) begin
                        starve_cnt <= '0;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    mem_req_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef REXTA_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_grants    <= '0;
            perf_ls_grants    <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (if_req_ready) begin
                perf_if_grants <= perf_if_grants + 32'd1;
            end
            if (ls_req_ready) begin
                perf_ls_grants <= perf_ls_grants + 32'd1;
            end
            if ((state == ST_REQ) && !mem_req_ready) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rexta_mem_arbiter.sv
// Bench for rexta_mem_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_rexta_mem_arbiter;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = '0;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_rdata;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_we = 1'b0;
    logic [31:0] ls_req_addr = '0;
    logic [31:0] ls_req_wdata = '0;
    logic [3:0]  ls_req_wstrb = '0;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        busy;
`ifdef REXTA_ARB_PERF_EN
    logic [31:0] perf_if_grants;
    logic [31:0] perf_ls_grants;
    logic [31:0] perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    rexta_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FETCH_STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
        .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
        .ls_req_wdata(ls_req_wdata), .ls_req_wstrb(ls_req_wstrb), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .busy(busy)
`ifdef REXTA_ARB_PERF_EN
        , .perf_if_grants(perf_if_grants), .perf_ls_grants(perf_ls_grants),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference memory contents, shared rule for the model and the memory responder.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Transaction-level model: at most one owned transaction, first pending at the
    // memory request, then pending on the response.
    logic [31:0] ref_mem [logic [31:0]];
    bit          m_req_pend, m_rsp_pend, m_owner_ls, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    int          m_starve;
    logic [31:0] m_pif, m_pls, m_pstall;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Memory responder (environment side).
    logic [31:0] drv_mem [logic [31:0]];
    bit          fixed_mode;
    int          fixed_delay;
    int          stall_left;
    bit          d_pend;
    int          d_cnt;
    logic [31:0] d_rdata;

    // Snapshots of the last sampled cycle, for directed checks.
    logic        s_if_ready, s_ls_ready, s_if_rsp, s_ls_rsp, s_mem_valid, s_mem_we, s_busy;
    logic [31:0] s_if_rdata, s_ls_rdata, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_wstrb;
    bit          dut_grants[$];

    task automatic model_reset();
        m_req_pend = 0; m_rsp_pend = 0; m_starve = 0;
        m_pif = '0; m_pls = '0; m_pstall = '0;
        d_pend = 0; stall_left = 0;
        dut_grants.delete();
    endtask

    task automatic cycle();
        bit free, if_win, ls_win, exp_ifr, exp_lsr;
        @(negedge clk);
        s_if_ready = if_req_ready; s_ls_ready = ls_req_ready;
        s_if_rsp = if_rsp_valid; s_ls_rsp = ls_rsp_valid;
        s_if_rdata = if_rsp_rdata; s_ls_rdata = ls_rsp_rdata;
        s_mem_valid = mem_req_valid; s_mem_we = mem_req_we; s_mem_addr = mem_req_addr;
        s_mem_wdata = mem_req_wdata; s_mem_wstrb = mem_req_wstrb; s_busy = busy;
        if (if_req_ready) dut_grants.push_back(1'b0);
        if (ls_req_ready) dut_grants.push_back(1'b1);

        free   = !m_req_pend && !m_rsp_pend;
        if_win = if_req_valid && (!ls_req_valid || m_starve == SMAX);
        ls_win = ls_req_valid && !if_win;
        chk1("if_req_ready", if_req_ready, free && if_win);
        chk1("ls_req_ready", ls_req_ready, free && ls_win);
        chk1("busy", busy, !free);
        chk1("mem_req_valid", mem_req_valid, m_req_pend);
        if (m_req_pend) begin
            chk32("mem_req_addr", mem_req_addr, m_addr);
            chk1("mem_req_we", mem_req_we, m_we);
            chk32("mem_req_wstrb", {28'd0, mem_req_wstrb}, {28'd0, m_wstrb});
            if (m_we) chk32("mem_req_wdata", mem_req_wdata, m_wdata);
        end
        exp_ifr = m_rsp_pend && mem_rsp_valid && !m_owner_ls;
        exp_lsr = m_rsp_pend && mem_rsp_valid && m_owner_ls;
        chk1("if_rsp_valid", if_rsp_valid, exp_ifr);
        chk1("ls_rsp_valid", ls_rsp_valid, exp_lsr);
        if (exp_ifr) chk32("if_rsp_rdata", if_rsp_rdata, ref_rd(m_addr));
        if (exp_lsr && !m_we) chk32("ls_rsp_rdata", ls_rsp_rdata, ref_rd(m_addr));
`ifdef REXTA_ARB_PERF_EN
        chk32("perf_if_grants", perf_if_grants, m_pif);
        chk32("perf_ls_grants", perf_ls_grants, m_pls);
        chk32("perf_stall_cycles", perf_stall_cycles, m_pstall);
`endif

        if (m_req_pend && !mem_req_ready) m_pstall++;
        if (m_rsp_pend && mem_rsp_valid) begin
            m_rsp_pend = 0;
            if (m_we) ref_mem[m_addr] = merge(ref_rd(m_addr), m_wdata, m_wstrb);
        end else if (m_req_pend && mem_req_ready) begin
            m_req_pend = 0;
            m_rsp_pend = 1;
        end else if (free) begin
            if (if_win) begin
                m_req_pend = 1; m_owner_ls = 0; m_we = 0;
                m_addr = if_req_addr; m_wdata = '0; m_wstrb = '0;
                m_starve = 0; m_pif++;
            end else if (ls_win) begin
                m_req_pend = 1; m_owner_ls = 1; m_we = ls_req_we;
                m_addr = ls_req_addr; m_wdata = ls_req_wdata;
                m_wstrb = ls_req_we ? ls_req_wstrb : 4'd0;
                m_starve = if_req_valid ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
                m_pls++;
            end else if (!if_req_valid) begin
                m_starve = 0;
            end
        end

        if (fixed_mode && mem_req_valid && !mem_req_ready && stall_left > 0) stall_left--;
        if (mem_req_valid && mem_req_ready) begin
            d_pend  = 1;
            d_cnt   = fixed_mode ? fixed_delay : int'($urandom_range(1, 3));
            d_rdata = drv_mem.exists(mem_req_addr) ? drv_mem[mem_req_addr] : init_word(mem_req_addr);
            if (mem_req_we) drv_mem[mem_req_addr] = merge(d_rdata, mem_req_wdata, mem_req_wstrb);
        end

        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = $urandom;
        if (d_pend) begin
            d_cnt--;
            if (d_cnt <= 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = d_rdata;
                d_pend = 0;
            end
        end else if (!fixed_mode && $urandom_range(0, 7) == 0) begin
            mem_rsp_valid = 1'b1;
        end
        mem_req_ready = fixed_mode ? (stall_left == 0) : ($urandom_range(0, 2) != 0);
    endtask

    task automatic apply_reset();
        if_req_valid = 0; ls_req_valid = 0; mem_rsp_valid = 0; mem_req_ready = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        mem_req_ready = fixed_mode ? 1'b1 : 1'b0;
    endtask

    task automatic wait_rsp(input string name, input bit is_ls, output logic [31:0] rd);
        bit found;
        found = 0;
        rd = '0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (is_ls ? s_ls_rsp : s_if_rsp) begin
                found = 1;
                rd = is_ls ? s_ls_rdata : s_if_rdata;
            end
        end
        chk1(name, found, 1'b1);
    endtask

    initial begin
        logic [31:0] rd;
        bit          seen;
        model_reset();
        fixed_mode = 1; fixed_delay = 2;

        // Reset values with a stray response during reset.
        mem_rsp_valid = 1;
        #12;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk1("rst_if_rsp_valid", if_rsp_valid, 1'b0);
        chk1("rst_ls_rsp_valid", ls_rsp_valid, 1'b0);
        chk32("rst_mem_req_addr", mem_req_addr, 32'h0);
        mem_rsp_valid = 0;
        apply_reset();

        // Single fetch from 0x100.
        drv_mem[32'h100] = 32'hDEAD_BEEF; ref_mem[32'h100] = 32'hDEAD_BEEF;
        drv_mem[32'h200] = 32'hAABB_CCDD; ref_mem[32'h200] = 32'hAABB_CCDD;
        if_req_valid = 1; if_req_addr = 32'h100;
        cycle();
        chk1("t1_if_ready_N", s_if_ready, 1'b1);
        chk1("t1_mem_valid_N", s_mem_valid, 1'b0);
        if_req_valid = 0;
        cycle();
        chk1("t1_mem_valid_N1", s_mem_valid, 1'b1);
        chk32("t1_mem_addr", s_mem_addr, 32'h100);
        wait_rsp("t1_if_rsp_seen", 1'b0, rd);
        chk32("t1_if_rdata", rd, 32'hDEAD_BEEF);
        cycle();
        chk1("t1_busy_after", s_busy, 1'b0);

        // Store with three stall cycles, then read it back.
        apply_reset();
        stall_left = 3;
        mem_req_ready = 0;
        ls_req_valid = 1; ls_req_we = 1; ls_req_addr = 32'h200;
        ls_req_wdata = 32'h1234_5678; ls_req_wstrb = 4'b0011;
        cycle();
        chk1("t4_ls_ready", s_ls_ready, 1'b1);
        ls_req_valid = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk1("t4_hold_valid", s_mem_valid, 1'b1);
            chk32("t4_hold_addr", s_mem_addr, 32'h200);
            chk32("t4_hold_wdata", s_mem_wdata, 32'h1234_5678);
            chk32("t4_hold_wstrb", {28'd0, s_mem_wstrb}, 32'h3);
            chk1("t4_hold_we", s_mem_we, 1'b1);
        end
        wait_rsp("t4_ls_rsp_seen", 1'b1, rd);
`ifdef REXTA_ARB_PERF_EN
        chk32("t4_perf_stall", perf_stall_cycles, 32'd3);
        chk32("t4_perf_ls", perf_ls_grants, 32'd1);
`endif
        cycle();
        ls_req_valid = 1; ls_req_we = 0; ls_req_wstrb = 4'hF;
        cycle();
        ls_req_valid = 0;
        cycle();
        chk32("t4_load_wstrb", {28'd0, s_mem_wstrb}, 32'h0);
        wait_rsp("t4_load_seen", 1'b1, rd);
        chk32("t4_load_rdata", rd, 32'hAABB_5678);

        // Both requesters valid continuously: LS x4, IF, LS x4, IF.
        apply_reset();
        fixed_delay = 1;
        if_req_valid = 1; if_req_addr = 32'h40;
        ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 32'h80;
        for (int i = 0; i < 200 && dut_grants.size() < 10; i++) cycle();
        chk32("t3_grant_count", dut_grants.size(), 32'd10);
        chk1("t2_first_is_ls", (dut_grants.size() > 0) ? dut_grants[0] : 1'b0, 1'b1);
        for (int i = 0; i < 10 && i < dut_grants.size(); i++)
            chk1("t3_grant_order", dut_grants[i], (i % 5) != 4);

        // Reset during WAIT, then a stray response and a normal fetch.
        apply_reset();
        fixed_delay = 3;
        ls_req_valid = 1; ls_req_we = 0; ls_req_addr = 32'h300;
        cycle();
        ls_req_valid = 0;
        cycle();
        if_req_valid = 1; if_req_addr = 32'h100;
        #2 rst_n = 0;
        #1;
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_mem_req_valid", mem_req_valid, 1'b0);
        chk1("t5_if_ready", if_req_ready, 1'b0);
        chk1("t5_ls_rsp", ls_rsp_valid, 1'b0);
        if_req_valid = 0;
        @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        mem_req_ready = 1;
        mem_rsp_valid = 1;
        cycle();
        chk1("t5_stray_ls_rsp", s_ls_rsp, 1'b0);
        chk1("t5_stray_if_rsp", s_if_rsp, 1'b0);
        chk1("t6_stray_busy", s_busy, 1'b0);
        if_req_valid = 1; if_req_addr = 32'h100;
        cycle();
        chk1("t5_refetch_ready", s_if_ready, 1'b1);
        if_req_valid = 0;
        wait_rsp("t5_refetch_seen", 1'b0, rd);
        chk32("t5_refetch_rdata", rd, 32'hDEAD_BEEF);

        // Randomized traffic.
        fixed_mode = 0;
        apply_reset();
        seen = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!if_req_valid || s_if_ready) begin
                if_req_valid = $urandom_range(0, 1);
                if_req_addr  = {26'd0, 4'($urandom), 2'b00};
            end else if ($urandom_range(0, 15) == 0) begin
                if_req_valid = 0;
            end
            if (!ls_req_valid || s_ls_ready) begin
                ls_req_valid = $urandom_range(0, 1);
                ls_req_we    = $urandom_range(0, 1);
                ls_req_addr  = {26'd0, 4'($urandom), 2'b00};
                ls_req_wdata = $urandom;
                ls_req_wstrb = 4'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                ls_req_valid = 0;
            end
            s_if_ready = 0; s_ls_ready = 0;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
